// File: rtl/nios_with_onchip_sdram_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot frames and offers them downstream over valid/ready.
// Optional DCT_DROP_COUNT_EN adds a saturating drop_count output.
module nios_with_onchip_sdram_cpu_oci_dct_packer #(
    parameter int unsigned ATOM_W  = 2,
    parameter int unsigned SLOTS   = 15,
    parameter int unsigned COUNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trace_enable,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom_data,
    input  logic                      flush,
    input  logic                      ovf_clear,
    input  logic                      frame_ready,
    output logic                      frame_valid,
    output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
    output logic [COUNT_W-1:0]        dct_count,
`ifdef DCT_DROP_COUNT_EN
    output logic [7:0]                drop_count,
`endif
    output logic                      overflow
);

    localparam int unsigned FRAME_W = ATOM_W * SLOTS;
    localparam logic [COUNT_W-1:0] FULL = COUNT_W'(SLOTS);

    logic [FRAME_W-1:0] pack_buf_q, pack_buf_d;
    logic [COUNT_W-1:0] pack_cnt_q, pack_cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [FRAME_W-1:0] out_buf_q, out_buf_d;
    logic [COUNT_W-1:0] out_cnt_q, out_cnt_d;
    logic               frame_valid_q, frame_valid_d;
    logic               overflow_q, overflow_d;
`ifdef DCT_DROP_COUNT_EN
    logic [7:0]         drop_cnt_q, drop_cnt_d;
`endif

    logic               out_free;
    logic               xfer;
    logic               en_atom;
    logic               accept;
    logic               drop;
    logic [COUNT_W-1:0] wr_slot;

    always_comb begin
        out_free = !frame_valid_q || frame_ready;
        xfer     = out_free && ((pack_cnt_q == FULL) ||
                                (flush_pend_q && (pack_cnt_q != '0)));
        en_atom  = trace_enable && atom_valid;
        accept   = en_atom && ((pack_cnt_q < FULL) || xfer);
        drop     = en_atom && (pack_cnt_q == FULL) && !xfer;
        // A transfer empties the pack register, so a same-cycle atom lands in slot 0.
        wr_slot  = xfer ? '0 : pack_cnt_q;
    end

    always_comb begin
        pack_buf_d = xfer ? '0 : pack_buf_q;
        pack_cnt_d = xfer ? '0 : pack_cnt_q;
        if (accept) begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                if (COUNT_W'(k) == wr_slot) begin
                    pack_buf_d[k*ATOM_W +: ATOM_W] = atom_data;
                end
            end
            pack_cnt_d = wr_slot + COUNT_W'(1);
        end
    end

    // A new flush request applies to whatever remains in the pack register after this cycle.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (flush) begin
            flush_pend_d = 1'b1;
        end else if (xfer || (pack_cnt_q == '0)) begin
            flush_pend_d = 1'b0;
        end
    end

    always_comb begin
        out_buf_d     = out_buf_q;
        out_cnt_d     = out_cnt_q;
        frame_valid_d = frame_valid_q;
        if (xfer) begin
            out_buf_d     = pack_buf_q;
            out_cnt_d     = pack_cnt_q;
            frame_valid_d = 1'b1;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clear) begin
            overflow_d = 1'b0;
        end
    end

`ifdef DCT_DROP_COUNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clear) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pack_buf_q    <= '0;
            pack_cnt_q    <= '0;
            flush_pend_q  <= 1'b0;
            out_buf_q     <= '0;
            out_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            pack_buf_q    <= pack_buf_d;
            pack_cnt_q    <= pack_cnt_d;
            flush_pend_q  <= flush_pend_d;
            out_buf_q     <= out_buf_d;
            out_cnt_q     <= out_cnt_d;
            frame_valid_q <= frame_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign dct_buffer  = out_buf_q;
    assign dct_count   = out_cnt_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_nios_with_onchip_sdram_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer; DCT_DROP_COUNT_EN also exercises drop_count.
module tb_nios_with_onchip_sdram_cpu_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_enable;
    logic        atom_valid;
    logic [1:0]  atom_data;
    logic        flush;
    logic        ovf_clear;
    logic        frame_ready;
    logic        frame_valid;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
`ifdef DCT_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nios_with_onchip_sdram_cpu_oci_dct_packer #(
        .ATOM_W (2),
        .SLOTS  (15),
        .COUNT_W(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_enable(trace_enable),
        .atom_valid  (atom_valid),
        .atom_data   (atom_data),
        .flush       (flush),
        .ovf_clear   (ovf_clear),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
`ifdef DCT_DROP_COUNT_EN
        .drop_count  (drop_count),
`endif
        .overflow    (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] d);
        atom_valid = 1'b1;
        atom_data  = d;
        tick();
        atom_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; trace_enable = 1'b1; atom_valid = 1'b0; atom_data = '0;
        flush = 1'b0; ovf_clear = 1'b0; frame_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_buf",   32'(dct_buffer),  32'd0);
        check("rst_cnt",   32'(dct_count),   32'd0);
        check("rst_ovf",   32'(overflow),    32'd0);
        reset = 1'b0;
        tick();

        // Fill with k%4, then with (k+1)%4
        for (int k = 0; k < 15; k++) send(2'(k % 4));
        check("fill_latency", 32'(frame_valid), 32'd0);
        tick();
        check("fill_valid", 32'(frame_valid), 32'd1);
        check("fill_cnt",   32'(dct_count),   32'd15);
        check("fill_buf",   32'(dct_buffer),  32'h24E4E4E4);
        tick();
        check("fill_pulse", 32'(frame_valid), 32'd0);
        for (int k = 0; k < 15; k++) send(2'((k + 1) % 4));
        tick();
        check("fill2_valid", 32'(frame_valid), 32'd1);
        check("fill2_buf",   32'(dct_buffer),  32'h39393939);
        tick();

        // Flush of a partial frame, then an empty flush
        send(2'd1); send(2'd2); send(2'd3);
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        check("flush_valid", 32'(frame_valid), 32'd1);
        check("flush_cnt",   32'(dct_count),   32'd3);
        check("flush_buf",   32'(dct_buffer),  32'h00000039);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_empty1", 32'(frame_valid), 32'd0);
        tick();
        check("flush_empty2", 32'(frame_valid), 32'd0);
        tick();
        check("flush_empty3", 32'(frame_valid), 32'd0);

        // Backpressure: 31 atoms, last one dropped
        frame_ready = 1'b0;
        for (int k = 0; k < 31; k++) send(2'(k % 4));
        check("bp_valid", 32'(frame_valid), 32'd1);
        check("bp_cnt",   32'(dct_count),   32'd15);
        check("bp_hold",  32'(dct_buffer),  32'h24E4E4E4);
        check("bp_ovf",   32'(overflow),    32'd1);
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("bp_ovf_clr", 32'(overflow), 32'd0);
        trace_enable = 1'b0;
        send(2'd1); send(2'd2);
        check("bp_dis_no_ovf", 32'(overflow),   32'd0);
        check("bp_still_held", 32'(dct_buffer), 32'h24E4E4E4);
        frame_ready = 1'b1;
        tick();
        check("bp_f2_valid", 32'(frame_valid), 32'd1);
        check("bp_f2_cnt",   32'(dct_count),   32'd15);
        check("bp_f2_buf",   32'(dct_buffer),  32'h13939393);
        tick();
        check("bp_drained", 32'(frame_valid), 32'd0);
        trace_enable = 1'b1;

        // Simultaneous full-pack transfer and atom; flush with atom
        for (int k = 0; k < 15; k++) send(2'd1);
        send(2'd2);
        check("sim_valid", 32'(frame_valid), 32'd1);
        check("sim_cnt",   32'(dct_count),   32'd15);
        check("sim_buf",   32'(dct_buffer),  32'h15555555);
        check("sim_ovf",   32'(overflow),    32'd0);
        flush = 1'b1; send(2'd3); flush = 1'b0;
        tick();
        check("simf_valid", 32'(frame_valid), 32'd1);
        check("simf_cnt",   32'(dct_count),   32'd2);
        check("simf_buf",   32'(dct_buffer),  32'h0000000E);
        tick();

        // Asynchronous reset mid-frame
        frame_ready = 1'b0;
        for (int k = 0; k < 15; k++) send(2'd2);
        tick();
        send(2'd1); send(2'd1);
        check("pre_rst_valid", 32'(frame_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 32'(frame_valid), 32'd0);
        check("arst_buf",   32'(dct_buffer),  32'd0);
        check("arst_cnt",   32'(dct_count),   32'd0);
        @(negedge clk) reset = 1'b0;
        frame_ready = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) send(2'd3);
        tick();
        check("post_rst_valid", 32'(frame_valid), 32'd1);
        check("post_rst_cnt",   32'(dct_count),   32'd15);
        check("post_rst_buf",   32'(dct_buffer),  32'h3FFFFFFF);
        tick();

`ifdef DCT_DROP_COUNT_EN
        frame_ready = 1'b0;
        for (int k = 0; k < 300; k++) send(2'(k % 4));
        check("drop_sat", 32'(drop_count), 32'd255);
        check("drop_ovf", 32'(overflow),   32'd1);
        ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
        check("drop_clr", 32'(drop_count), 32'd0);
        ovf_clear = 1'b1; send(2'd0); ovf_clear = 1'b0;
        check("drop_clr_race", 32'(drop_count), 32'd1);
        trace_enable = 1'b0;
        for (int k = 0; k < 5; k++) send(2'd1);
        check("drop_disabled", 32'(drop_count), 32'd1);
        trace_enable = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
